// File: rtl/grad_frame_sequencer.sv
// grad_frame_sequencer
// Frame-level controller for the Sobel gradient filter. Gates the 3x3 window
// stream into the filter and drives start/matrix_clken/data_valid. It tracks
// the row/col of the next window and counts filter results. A frame completes
// once all interior results have drained.
// Optional feature: define GRAD_SEQ_TIMEOUT_EN to add a drain watchdog that
// sets a sticky err and forces frame completion after DRAIN_MAX idle cycles.
module grad_frame_sequencer #(
    parameter int WIDTH     = 512,
    parameter int DEPTH     = 638,
    parameter int DRAIN_MAX = 64,
    parameter int CNT_W     = $clog2(WIDTH*DEPTH+1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_frame_go,
    input  logic                     i_pix_valid,
    output logic                     o_pix_ready,
    output logic                     o_start,
    output logic                     o_matrix_clken,
    output logic                     o_data_valid,
    input  logic                     i_ready_sync,
    input  logic                     i_data_en,
    output logic                     o_busy,
    output logic                     o_frame_done,
    output logic                     o_err,
    output logic [$clog2(WIDTH)-1:0] o_col,
    output logic [$clog2(DEPTH)-1:0] o_row,
    output logic [CNT_W-1:0]         o_out_count
);

    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] EXPECT = CNT_W'((WIDTH-2)*(DEPTH-2));

    if (WIDTH < 3 || DEPTH < 3 || DRAIN_MAX < 1) begin : g_param_check
        $error("grad_frame_sequencer: WIDTH/DEPTH must be >= 3 and DRAIN_MAX >= 1");
    end

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_accept;
    logic              w_last_col;
    logic              w_last_row;
    logic              w_count_en;
    logic              w_drain_hit;
    logic              w_timeout;
    logic              w_go;

    assign w_go        = (r_state == S_IDLE) && i_frame_go;
    assign w_accept    = (r_state == S_RUN) && i_pix_valid;
    assign w_last_col  = (r_col == COL_W'(WIDTH-1));
    assign w_last_row  = (r_row == ROW_W'(DEPTH-1));
    assign w_count_en  = i_data_en &&
                         (r_state == S_ARM || r_state == S_RUN || r_state == S_DRAIN);
    // Saturating result count; the drain exit looks at the post-increment value
    // so a result arriving in the final cycle still completes the frame.
    assign w_cnt_next  = (w_count_en && !(&r_cnt)) ? r_cnt + 1'b1 : r_cnt;
    assign w_drain_hit = (w_cnt_next >= EXPECT);

`ifdef GRAD_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(DRAIN_MAX + 1);
    // r_wd holds cycles elapsed since DRAIN entry or the last result; the
    // result cycle itself counts as zero, so the next cycle starts at one.
    logic [WD_W-1:0] r_wd;
    logic            r_err;

    assign w_timeout = (r_state == S_DRAIN) && !i_data_en &&
                       (r_wd == WD_W'(DRAIN_MAX - 1));

    // Drain watchdog: cleared outside DRAIN and on every result
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                   r_wd <= '0;
        else if (r_state != S_DRAIN) r_wd <= '0;
        else if (i_data_en)          r_wd <= WD_W'(1);
        else                         r_wd <= r_wd + 1'b1;
    end

    // Sticky error: set on watchdog expiry, cleared by the next accepted frame_go
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                         r_err <= 1'b0;
        else if (w_go)                     r_err <= 1'b0;
        else if (w_timeout && !w_drain_hit) r_err <= 1'b1;
    end

    assign o_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign o_err     = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_frame_go) w_next = S_ARM;
            S_ARM:   if (i_ready_sync) w_next = S_RUN;
            S_RUN:   if (w_accept && w_last_col && w_last_row) w_next = S_DRAIN;
            S_DRAIN: if (w_drain_hit || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Filter-facing controls, decoded from the state and the live window handshake
    always_comb begin
        o_start        = 1'b0;
        o_pix_ready    = 1'b0;
        o_matrix_clken = 1'b0;
        o_data_valid   = 1'b0;
        o_frame_done   = 1'b0;
        o_busy         = (r_state != S_IDLE);
        case (r_state)
            S_ARM:   o_start = 1'b1;
            S_RUN: begin
                o_start        = 1'b1;
                o_pix_ready    = 1'b1;
                o_matrix_clken = i_pix_valid;
                o_data_valid   = i_pix_valid &&
                                 (r_row == '0 || w_last_row || r_col == '0 || w_last_col);
            end
            S_DRAIN: o_start = 1'b1;
            S_DONE:  o_frame_done = 1'b1;
            default: o_start = 1'b0;
        endcase
    end

    // Raster position of the next window; wraps to (0,0) after the last one
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_go) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Result counter, restarted by each accepted frame_go
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)     r_cnt <= '0;
        else if (w_go) r_cnt <= '0;
        else           r_cnt <= w_cnt_next;
    end

    assign o_col       = r_col;
    assign o_row       = r_row;
    assign o_out_count = r_cnt;

endmodule

// File: tb/tb_grad_frame_sequencer.sv
// tb_grad_frame_sequencer
// Randomized bench for grad_frame_sequencer at WIDTH=DEPTH=4, DRAIN_MAX=8.
// A filter stand-in returns data_en 24 cycles after each interior window and
// ready_sync as start delayed 24 cycles. A frame-level reference model
// (accepted-window count, result count, timestamps) predicts every output on
// every cycle. Honours GRAD_SEQ_TIMEOUT_EN.
module tb_grad_frame_sequencer;

    localparam int W   = 4;
    localparam int D   = 4;
    localparam int DM  = 8;
    localparam int N   = W * D;
    localparam int EXP = (W - 2) * (D - 2);
    localparam int LAT = 24;
    localparam int CW  = $clog2(W * D + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          go  = 1'b0;
    logic          pv  = 1'b0;
    logic          rs  = 1'b0;
    logic          de  = 1'b0;
    logic          pr, st, ck, dv, busy, fd, err;
    logic [1:0]    col, row;
    logic [CW-1:0] cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    grad_frame_sequencer #(
        .WIDTH(W), .DEPTH(D), .DRAIN_MAX(DM), .CNT_W(CW)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_frame_go(go), .i_pix_valid(pv),
        .o_pix_ready(pr), .o_start(st), .o_matrix_clken(ck), .o_data_valid(dv),
        .i_ready_sync(rs), .i_data_en(de), .o_busy(busy), .o_frame_done(fd),
        .o_err(err), .o_col(col), .o_row(row), .o_out_count(cnt)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame-level) ----------------
    int cyc        = 0;
    bit m_inframe  = 0;   // a frame was accepted and has not finished
    bit m_armed    = 0;   // filter pipeline reported ready for this frame
    bit m_donecyc  = 0;   // this cycle is the completion cycle
    bit m_err      = 0;
    int m_acc      = 0;   // windows accepted this frame
    int m_cnt      = 0;   // results counted this frame
    int m_last_evt = 0;   // cycle of drain entry or last result while draining

    task automatic model_step();
        if (rst) begin
            m_inframe = 0; m_armed = 0; m_donecyc = 0; m_err = 0;
            m_acc = 0; m_cnt = 0;
        end else if (m_donecyc) begin
            m_donecyc = 0;
        end else if (!m_inframe) begin
            if (go) begin
                m_inframe = 1; m_armed = 0; m_acc = 0; m_cnt = 0; m_err = 0;
            end
        end else begin
            if (de && m_cnt < (2**CW) - 1) m_cnt++;
            if (!m_armed) begin
                if (rs) m_armed = 1;
            end else if (m_acc < N) begin
                if (pv) begin
                    m_acc++;
                    if (m_acc == N) m_last_evt = cyc + 1;
                end
            end else begin
                if (de) m_last_evt = cyc;
                if (m_cnt >= EXP) begin
                    m_inframe = 0; m_donecyc = 1;
                end
`ifdef GRAD_SEQ_TIMEOUT_EN
                else if (cyc + 1 - m_last_evt >= DM) begin
                    m_inframe = 0; m_donecyc = 1; m_err = 1;
                end
`endif
            end
        end
    endtask

    // ---------------- monitors ----------------
    bit s_st = 0, s_ck = 0, s_dv = 0, s_fd = 0, s_rst = 1;
    int n_ck = 0, n_dv = 0, n_de = 0, n_fd = 0;
    int de_last = 0, fd_cyc = 0, fd_cnt = 0, fd_err = 0;

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin : cmp
        bit arm_p, run_p, drain_p;
        bit e_st, e_pr, e_ck, e_dv, e_busy, e_fd, e_err;
        int e_col, e_row, e_cnt;
        arm_p   = m_inframe && !m_armed;
        run_p   = m_inframe && m_armed && (m_acc < N);
        drain_p = m_inframe && m_armed && (m_acc >= N);
        e_col   = m_acc % W;
        e_row   = (m_acc / W) % D;
        e_st    = arm_p || run_p || drain_p;
        e_pr    = run_p;
        e_ck    = run_p && pv;
        e_dv    = e_ck && (e_row == 0 || e_row == D-1 || e_col == 0 || e_col == W-1);
        e_busy  = m_inframe || m_donecyc;
        e_fd    = m_donecyc;
        e_err   = m_err;
        e_cnt   = m_cnt;
        if (rst) begin
            {e_st, e_pr, e_ck, e_dv, e_busy, e_fd, e_err} = '0;
            e_col = 0; e_row = 0; e_cnt = 0;
        end
        chk("start",        st,   e_st);
        chk("pix_ready",    pr,   e_pr);
        chk("matrix_clken", ck,   e_ck);
        chk("data_valid",   dv,   e_dv);
        chk("busy",         busy, e_busy);
        chk("frame_done",   fd,   e_fd);
        chk("err",          err,  e_err);
        chk("col",          col,  e_col);
        chk("row",          row,  e_row);
        chk("out_count",    cnt,  e_cnt);
        s_st = st; s_ck = ck; s_dv = dv; s_fd = fd; s_rst = rst;
        if (ck) n_ck++;
        if (ck && dv) n_dv++;
        if (de) begin n_de++; de_last = cyc; end
        if (fd) begin n_fd++; fd_cyc = cyc; fd_cnt = cnt; fd_err = err; end
    end

    // ---------------- filter stand-in ----------------
    bit rs_q[$];
    bit de_q[$];
    int n_int    = 0;
    bit suppress = 0;

    task automatic filter_clear();
        rs_q.delete(); de_q.delete();
        for (int i = 0; i < LAT; i++) begin rs_q.push_back(1'b0); de_q.push_back(1'b0); end
        rs = 1'b0; de = 1'b0; n_int = 0;
    endtask

    task automatic filter_step();
        bit push_de;
        if (s_rst) begin
            filter_clear();
        end else begin
            push_de = s_ck && !s_dv;
            if (push_de) begin
                if (suppress && n_int == 3) push_de = 1'b0;
                n_int++;
            end
            rs_q.push_back(s_st);
            de_q.push_back(push_de);
            rs = rs_q.pop_front();
            de = de_q.pop_front();
            if (s_fd) n_int = 0;
        end
    endtask

    always begin : edge_proc
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        filter_step();
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: pix_valid=1, 1: alternate, 2: random, 3: stall after 10 accepts
    task automatic run_frame(input int mode, input bit noise, input int budget, output bit ok);
        int fd0, gap, k;
        fd0 = n_fd; gap = 0; k = 0; ok = 0;
        n_ck = 0; n_dv = 0; n_de = 0;
        go = 1'b1;
        step();
        go = 1'b0;
        while (k < budget) begin
            case (mode)
                0: pv = 1'b1;
                1: pv = ~pv;
                2: pv = 1'($urandom_range(0, 1));
                default: begin
                    if (n_ck >= 10 && gap < 10) begin pv = 1'b0; gap++; end
                    else pv = 1'b1;
                end
            endcase
            go = noise && m_inframe && ($urandom_range(0, 3) == 0);
            step();
            if (n_fd != fd0) begin ok = 1; break; end
            k++;
        end
        go = 1'b0;
        pv = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit ok;
        int fd0, k;
        filter_clear();

        // 1: reset with random inputs; frame_go during reset has no effect
        repeat (3) begin
            pv = 1'($urandom_range(0, 1));
            go = 1'($urandom_range(0, 1));
            step();
        end
        rst = 1'b0; go = 1'b0; pv = 1'b0;
        step();
        chk("t1_busy_after_rst", busy, 0);
        chk("t1_start_after_rst", st, 0);
        repeat (5) step();

        // 2: full frame, pix_valid held high
        run_frame(0, 0, 200, ok);
        chk("t2_done_seen", ok, 1);
        chk("t2_clken", n_ck, 16);
        chk("t2_border", n_dv, 12);
        chk("t2_results", n_de, 4);
        chk("t2_count_at_done", fd_cnt, 4);
        chk("t2_done_latency", fd_cyc - de_last, 1);
        chk("t2_idle_after", busy, 0);
        repeat (30) step();

        // 3: alternating pix_valid
        fd0 = n_fd;
        run_frame(1, 0, 200, ok);
        chk("t3_done_seen", ok, 1);
        chk("t3_clken", n_ck, 16);
        chk("t3_results", n_de, 4);
        chk("t3_done_once", n_fd - fd0, 1);
        repeat (30) step();

        // random pix_valid
        run_frame(2, 0, 300, ok);
        chk("tr_done_seen", ok, 1);
        chk("tr_clken", n_ck, 16);
        chk("tr_count_at_done", fd_cnt, 4);
        repeat (30) step();

        // 4: frame_go noise during the frame, then immediate second frame
        fd0 = n_fd;
        run_frame(0, 1, 200, ok);
        chk("t4_done_seen", ok, 1);
        chk("t4_done_once", n_fd - fd0, 1);
        run_frame(0, 0, 200, ok);
        chk("t4b_done_seen", ok, 1);
        chk("t4b_clken", n_ck, 16);
        chk("t4b_count_fresh", fd_cnt, 4);
        repeat (30) step();

        // 5: reset after 7 accepted windows aborts the frame
        fd0 = n_fd; n_ck = 0; k = 0;
        go = 1'b1; step(); go = 1'b0;
        while (n_ck < 7 && k < 200) begin pv = 1'b1; step(); k++; end
        chk("t5_accepted", n_ck, 7);
        rst = 1'b1; pv = 1'b0;
        #1;
        chk("t5_start_drop", st, 0);
        chk("t5_busy_drop", busy, 0);
        step();
        rst = 1'b0;
        repeat (30) step();
        chk("t5_no_done", n_fd - fd0, 0);
        run_frame(0, 0, 200, ok);
        chk("t5_restart_done", ok, 1);
        chk("t5_restart_clken", n_ck, 16);
        chk("t5_restart_count", fd_cnt, 4);
        repeat (30) step();

        // 6: fourth result suppressed
        suppress = 1'b1;
`ifdef GRAD_SEQ_TIMEOUT_EN
        run_frame(3, 0, 200, ok);
        chk("t6_done_seen", ok, 1);
        chk("t6_results", n_de, 3);
        chk("t6_err_at_done", fd_err, 1);
        chk("t6_timeout_latency", fd_cyc - de_last, DM);
        step();
        chk("t6_err_sticky", err, 1);
        suppress = 1'b0;
        repeat (30) step();
        run_frame(0, 0, 200, ok);
        chk("t6_next_done", ok, 1);
        chk("t6_err_cleared", err, 0);
`else
        run_frame(3, 0, 80, ok);
        chk("t6_no_done", ok, 0);
        chk("t6_results", n_de, 3);
        chk("t6_still_busy", busy, 1);
        chk("t6_no_err", err, 0);
        suppress = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (30) step();
        run_frame(0, 0, 200, ok);
        chk("t6_recover_done", ok, 1);
`endif
        repeat (5) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
